// File: rtl/sdp_y_core_cfg_triosy_ctrl.sv
// Layer-completion scheduler for the SDP Y core config triosy channels: it collects per-channel done, then handshakes once, then pulses lz.
// Latency: when the last ch_done arrives in cycle t, done_vld is high at t+1; triosy_lz is high in the cycle after the handshake.
// Backpressure: done_vld stays asserted until done_rdy is sampled high; it is never withdrawn.
module sdp_y_core_cfg_triosy_ctrl #(
    parameter int NUM_CH = 4,
    parameter int TO_W   = 8
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              layer_start,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic              done_rdy,
    input  logic [TO_W-1:0]   timeout_limit,
    input  logic              err_clr,
    output logic              done_vld,
    output logic [NUM_CH-1:0] triosy_lz,
    output logic [NUM_CH-1:0] ch_pending,
    output logic              busy,
    output logic              timeout_err,
    output logic              start_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            state_q;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] pend_q;
    logic [TO_W-1:0]   cnt_q;
    logic [NUM_CH-1:0] lz_q;
    logic              tmo_err_q;
    logic              start_err_q;

    logic [NUM_CH-1:0] pend_d;
    logic [TO_W-1:0]   cnt_d;
    logic              tmo_set;
    logic              start_set;

    // Next-cycle helpers: outstanding set after this cycle's completions, saturating watchdog count, error set conditions.
    always_comb begin
        pend_d    = pend_q & ~ch_done;
        cnt_d     = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        tmo_set   = (state_q == ST_COLLECT) && (timeout_limit != '0) && (cnt_d == timeout_limit);
        start_set = layer_start && (state_q != ST_IDLE);
    end

    // Layer sequencing FSM with registered lz pulse and sticky error flags (a set beats a same-cycle clear).
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            pend_q      <= '0;
            cnt_q       <= '0;
            lz_q        <= '0;
            tmo_err_q   <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            lz_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (layer_start) begin
                        mask_q  <= ch_en;
                        pend_q  <= ch_en;
                        cnt_q   <= '0;
                        state_q <= (ch_en == '0) ? ST_DONE : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    pend_q <= pend_d;
                    cnt_q  <= cnt_d;
                    if (pend_d == '0) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (done_rdy) begin
                        lz_q    <= mask_q;
                        pend_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (tmo_set) begin
                tmo_err_q <= 1'b1;
            end else if (err_clr) begin
                tmo_err_q <= 1'b0;
            end

            if (start_set) begin
                start_err_q <= 1'b1;
            end else if (err_clr) begin
                start_err_q <= 1'b0;
            end
        end
    end

    // Status outputs decoded directly from the state register.
    always_comb begin
        done_vld    = (state_q == ST_DONE);
        busy        = (state_q != ST_IDLE);
        ch_pending  = (state_q == ST_COLLECT) ? pend_q : '0;
        triosy_lz   = lz_q;
        timeout_err = tmo_err_q;
        start_err   = start_err_q;
    end

endmodule

// File: tb/tb_sdp_y_core_cfg_triosy_ctrl.sv
// Bench for the config triosy layer-completion scheduler.
// Holds an event-level model of a layer (open, outstanding set, waiting for sequencer) and compares it every cycle.
// Directed scenarios also carry hand-computed literal checks that pin the model.
module tb_sdp_y_core_cfg_triosy_ctrl;

    localparam int NUM_CH = 4;
    localparam int TO_W   = 8;

    logic              clk;
    logic              rstn;
    logic              layer_start;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_done;
    logic              done_rdy;
    logic [TO_W-1:0]   timeout_limit;
    logic              err_clr;
    logic              done_vld;
    logic [NUM_CH-1:0] triosy_lz;
    logic [NUM_CH-1:0] ch_pending;
    logic              busy;
    logic              timeout_err;
    logic              start_err;

    int n_vec = 0;
    int n_bad = 0;
    bit run_chk = 0;

    sdp_y_core_cfg_triosy_ctrl #(.NUM_CH(NUM_CH), .TO_W(TO_W)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .layer_start     (layer_start),
        .ch_en           (ch_en),
        .ch_done         (ch_done),
        .done_rdy        (done_rdy),
        .timeout_limit   (timeout_limit),
        .err_clr         (err_clr),
        .done_vld        (done_vld),
        .triosy_lz       (triosy_lz),
        .ch_pending      (ch_pending),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .start_err       (start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit                m_open;      // a layer has been accepted and not yet handed back
    bit                m_waiting;   // every participant finished, sequencer not yet taken it
    logic [NUM_CH-1:0] m_mask;
    logic [NUM_CH-1:0] m_out;       // participants yet to report
    int                m_age;       // cycles spent collecting
    logic [NUM_CH-1:0] m_lz;
    bit                m_terr;
    bit                m_serr;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_open = 0; m_waiting = 0; m_mask = '0; m_out = '0;
            m_age = 0; m_lz = '0; m_terr = 0; m_serr = 0;
        end else begin
            logic [NUM_CH-1:0] lz_now;
            bit t_hit, s_hit;
            int age_sat;
            lz_now = '0; t_hit = 0; s_hit = 0;
            if (!m_open) begin
                if (layer_start) begin
                    m_open = 1; m_mask = ch_en; m_out = ch_en; m_age = 0;
                    m_waiting = (ch_en == 0);
                end
            end else begin
                if (layer_start) s_hit = 1;
                if (m_waiting) begin
                    if (done_rdy) begin
                        lz_now = m_mask; m_open = 0; m_waiting = 0;
                    end
                end else begin
                    m_out = m_out & ~ch_done;
                    m_age = m_age + 1;
                    age_sat = (m_age > 255) ? 255 : m_age;
                    if (timeout_limit != 0 && age_sat == int'(timeout_limit)) t_hit = 1;
                    if (m_out == 0) m_waiting = 1;
                end
            end
            m_lz = lz_now;
            if (t_hit) m_terr = 1; else if (err_clr) m_terr = 0;
            if (s_hit) m_serr = 1; else if (err_clr) m_serr = 0;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("m_done_vld",    {31'd0, done_vld},    {31'd0, m_waiting});
            chk("m_busy",        {31'd0, busy},        {31'd0, m_open});
            chk("m_ch_pending",  {28'd0, ch_pending},  (m_open && !m_waiting) ? {28'd0, m_out} : 32'd0);
            chk("m_triosy_lz",   {28'd0, triosy_lz},   {28'd0, m_lz});
            chk("m_timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
            chk("m_start_err",   {31'd0, start_err},   {31'd0, m_serr});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_vld"},  {31'd0, done_vld},   32'd0);
        chk({nm, "_lz"},   {28'd0, triosy_lz},  32'd0);
        chk({nm, "_pend"}, {28'd0, ch_pending}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy},       32'd0);
        chk({nm, "_terr"}, {31'd0, timeout_err}, 32'd0);
        chk({nm, "_serr"}, {31'd0, start_err},  32'd0);
    endtask

    initial begin
        rstn = 1'b0; layer_start = 0; ch_en = '0; ch_done = '0;
        done_rdy = 0; timeout_limit = '0; err_clr = 0;
        repeat (3) cyc();
        run_chk = 1;
        chk_zero("reset");
        rstn = 1'b1;
        cyc();

        // 1: mask 1011, completions one per cycle, sequencer ready
        done_rdy = 1; layer_start = 1; ch_en = 4'b1011; cyc();
        layer_start = 0; ch_en = '0;
        chk("t1_pend0", {28'd0, ch_pending}, 32'hB);
        ch_done = 4'b0001; cyc(); chk("t1_pend1", {28'd0, ch_pending}, 32'hA);
        ch_done = 4'b0010; cyc(); chk("t1_pend2", {28'd0, ch_pending}, 32'h8);
        ch_done = 4'b1000; cyc();
        chk("t1_vld", {31'd0, done_vld}, 32'd1);
        chk("t1_pend3", {28'd0, ch_pending}, 32'h0);
        ch_done = '0; cyc();
        chk("t1_lz", {28'd0, triosy_lz}, 32'hB);
        chk("t1_vld_off", {31'd0, done_vld}, 32'd0);
        cyc();
        chk("t1_lz_off", {28'd0, triosy_lz}, 32'h0);
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // 2: sequencer stalls for 5 cycles
        done_rdy = 0; layer_start = 1; ch_en = 4'b0110; cyc();
        layer_start = 0; ch_en = '0; ch_done = 4'b0110; cyc();
        ch_done = '0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_vld_hold", {31'd0, done_vld}, 32'd1);
            chk("t2_lz_quiet", {28'd0, triosy_lz}, 32'h0);
            cyc();
        end
        done_rdy = 1; cyc();
        chk("t2_lz", {28'd0, triosy_lz}, 32'h6);
        cyc();
        chk("t2_lz_off", {28'd0, triosy_lz}, 32'h0);

        // 3: completion noise
        ch_done = 4'b1111; cyc();
        chk("t3_idle_noise", {31'd0, busy}, 32'd0);
        ch_done = '0; layer_start = 1; ch_en = 4'b0001; cyc();
        layer_start = 0; ch_en = '0; ch_done = 4'b1110; cyc();
        chk("t3_foreign", {28'd0, ch_pending}, 32'h1);
        ch_done = 4'b0001; cyc();
        chk("t3_done", {31'd0, done_vld}, 32'd1);
        cyc();                                  // duplicate bit 0 during handshake
        chk("t3_lz", {28'd0, triosy_lz}, 32'h1);
        ch_done = '0; cyc();
        chk("t3_idle", {31'd0, busy}, 32'd0);
        chk("t3_lz_once", {28'd0, triosy_lz}, 32'h0);

        // 4: empty mask
        layer_start = 1; ch_en = 4'b0000; cyc();
        layer_start = 0;
        chk("t4_vld", {31'd0, done_vld}, 32'd1);
        cyc();
        chk("t4_lz", {28'd0, triosy_lz}, 32'h0);
        chk("t4_idle", {31'd0, busy}, 32'd0);

        // 5: watchdog at 3 cycles, channel 1 late
        timeout_limit = 8'd3; layer_start = 1; ch_en = 4'b0011; cyc();
        layer_start = 0; ch_en = '0; ch_done = 4'b0001; cyc();
        ch_done = '0; cyc();
        chk("t5_terr_early", {31'd0, timeout_err}, 32'd0);
        cyc();
        chk("t5_terr", {31'd0, timeout_err}, 32'd1);
        chk("t5_still_collect", {28'd0, ch_pending}, 32'h2);
        cyc(); cyc();
        ch_done = 4'b0010; cyc();
        ch_done = '0;
        chk("t5_done", {31'd0, done_vld}, 32'd1);
        cyc();
        chk("t5_lz", {28'd0, triosy_lz}, 32'h3);
        timeout_limit = '0; err_clr = 1; cyc();
        err_clr = 0;
        chk("t5_clr", {31'd0, timeout_err}, 32'd0);

        // 6: start while busy, then reset mid-collect
        layer_start = 1; ch_en = 4'b1100; cyc();
        ch_en = 4'b0011; cyc();
        layer_start = 0; ch_en = '0;
        chk("t6_serr", {31'd0, start_err}, 32'd1);
        chk("t6_pend_kept", {28'd0, ch_pending}, 32'hC);
        ch_done = 4'b0100; cyc();
        ch_done = '0;
        chk("t6_pend_step", {28'd0, ch_pending}, 32'h8);
        #2 rstn = 1'b0;
        #1 chk_zero("t6_arst");
        cyc(); cyc();
        rstn = 1'b1;
        ch_done = 4'b1000; done_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t6_no_lz", {28'd0, triosy_lz}, 32'h0);
        end
        ch_done = '0;
        cyc();
        run_chk = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
